tlc1543_ioclk_gen: RTL
======================

// Module: tlc1543_ioclk_gen
// PURPOSE
//  Generates the TLC1543 I/O CLOCK burst and chip select for one conversion frame: the edge source on the
//  transmit side of the serial ADC interface.
//  - Emits PARAM_PULSES io_clk periods framed by cs_n.
//  - Emits single-cycle sig_rising/sig_falling strobes in the same cycle io_clk changes, so address-shift
//    and data-capture logic act without re-detecting edges.
// PARAMETERS
//  DIV_HALF  25  clk_in cycles per io_clk half-period; legal 1..65535
//  PULSES    10  io_clk rising edges per frame; legal 1..15
//  CNT_W     16  width of half-period counter; must hold DIV_HALF-1
// PORTS
//  clk_in       in   1  system clock, all logic on posedge
//  rst_in       in   1  synchronous reset, active-high
//  start_in     in   1  frame request; sampled only while busy==0
//  io_clk       out  1  ADC I/O CLOCK, registered, idles low
//  cs_n         out  1  ADC chip select, registered, active-low, idles high
//  sig_rising   out  1  1-cycle strobe, high in the cycle io_clk goes 0->1
//  sig_falling  out  1  1-cycle strobe, high in the cycle io_clk goes 1->0
//  pulse_idx    out  4  count of rising edges issued in current frame
//  busy         out  1  high from cs_n assertion until frame end
//  done         out  1  1-cycle strobe at frame end
// BEHAVIOUR
//  - Reset: io_clk=0, cs_n=1, sig_rising=0, sig_falling=0, pulse_idx=0, busy=0, done=0, state=IDLE,
//    counter=0. Reset mid-frame aborts the frame at the next edge; no done strobe.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - FSM: IDLE -> SETUP -> HIGH <-> LOW -> HOLD -> IDLE.
//    - IDLE: start_in=1 at edge 0 -> edge 1: cs_n=0, busy=1, pulse_idx=0, state=SETUP.
//    - SETUP: io_clk low for DIV_HALF cycles (CS setup doubles as first low phase).
//    - Rising edge k (k=1..PULSES) at edge 1+(2k-1)*DIV_HALF: io_clk=1, sig_rising=1, pulse_idx=k.
//    - Falling edge k at edge 1+2k*DIV_HALF: io_clk=0, sig_falling=1.
//    - After falling edge PULSES, enter HOLD with io_clk low for DIV_HALF cycles.
//    - Then at edge 1+(2*PULSES+1)*DIV_HALF: cs_n=1, busy=0, done=1 for one cycle, state=IDLE.
//  - Frame length: (2*PULSES+1)*DIV_HALF cycles from cs_n low to cs_n high.
//  - start_in while busy=1 is ignored, not queued.
//  - start_in high in the done cycle is accepted (busy=0), giving back-to-back frames with cs_n high for
//    exactly 1 cycle.
//  - Half-period counter counts 0..DIV_HALF-1 and wraps. With DIV_HALF=1, io_clk toggles every cycle and
//    the strobes alternate every cycle.
//  - pulse_idx holds its last value (PULSES) after the frame until the next accepted start clears it to 0.
//  - sig_rising and sig_falling are never high in the same cycle.
// CONFIGURATION
//  IOCLK_EOC_WAIT_EN defined:
//    - Adds input port eoc_in (1 bit, ADC EOC, synchronised externally).
//    - After the done cycle, the FSM enters WAIT_EOC with busy=1 and cs_n=1.
//    - It returns to IDLE (busy=0) in the cycle after eoc_in is sampled 0 then 1 (rising edge).
//    - done still pulses at frame end; start_in is ignored in WAIT_EOC.
//  IOCLK_EOC_WAIT_EN undefined: no eoc_in port and no WAIT_EOC state; behaviour as above.
// TESTING
//  1 DIV_HALF=2, PULSES=10, start at edge 0 -> cs_n=0 at edge 1, rises at 3,7,...,39, falls at 5,9,...,41,
//    cs_n=1 and done=1 at 43, busy low at 43.
//  2 Same config, start held high continuously -> second frame cs_n=0 at edge 44; cs_n high only at edge 43.
//  3 start pulsed at edges 10 and 20 during a frame -> no effect; exactly 10 sig_rising strobes, one done.
//  4 rst_in=1 at edge 15 mid-frame -> edge 16: io_clk=0, cs_n=1, busy=0, pulse_idx=0; no done pulse.
//  5 DIV_HALF=1, PULSES=1 -> cs_n low at 1, rise at 2, fall at 3, done at 4; strobes never overlap.
//  6 IOCLK_EOC_WAIT_EN, default params, eoc_in held 0 for 100 cycles after done, then 1 -> busy stays 1
//    until the cycle after eoc_in rises; start ignored meanwhile.

Source files
------------

// File: rtl/tlc1543_ioclk_gen.sv
// TLC1543 I/O CLOCK burst and chip-select generator for one conversion frame.
// Optional macro IOCLK_EOC_WAIT_EN: adds eoc_in and holds busy until the ADC signals EOC.
module tlc1543_ioclk_gen #(
    parameter int DIV_HALF = 25,
    parameter int PULSES   = 10,
    parameter int CNT_W    = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       start_in,
`ifdef IOCLK_EOC_WAIT_EN
    input  logic       eoc_in,
`endif
    output logic       io_clk,
    output logic       cs_n,
    output logic       sig_rising,
    output logic       sig_falling,
    output logic [3:0] pulse_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_WAIT_EOC
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;
    logic             io_clk_q, cs_n_q, rise_q, fall_q, busy_q, done_q;
    logic [3:0]       pidx_q;
`ifdef IOCLK_EOC_WAIT_EN
    logic             eoc_q;
`endif

    // Half-period counter runs 0..DIV_HALF-1; every wrap is an io_clk phase boundary.
    assign wrap  = (cnt_q == CNT_W'(DIV_HALF - 1));
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            io_clk_q <= 1'b0;
            cs_n_q   <= 1'b1;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            pidx_q   <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef IOCLK_EOC_WAIT_EN
            eoc_q    <= 1'b0;
`endif
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            done_q <= 1'b0;
`ifdef IOCLK_EOC_WAIT_EN
            eoc_q  <= eoc_in;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_in) begin
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        pidx_q  <= 4'd0;
                        state_q <= S_SETUP;
                    end
                end
                // CS setup time doubles as the first low phase.
                S_SETUP, S_LOW: begin
                    cnt_q <= cnt_d;
                    if (wrap) begin
                        io_clk_q <= 1'b1;
                        rise_q   <= 1'b1;
                        pidx_q   <= pidx_q + 4'd1;
                        state_q  <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    cnt_q <= cnt_d;
                    if (wrap) begin
                        io_clk_q <= 1'b0;
                        fall_q   <= 1'b1;
                        state_q  <= (pidx_q == 4'(PULSES)) ? S_HOLD : S_LOW;
                    end
                end
                S_HOLD: begin
                    cnt_q <= cnt_d;
                    if (wrap) begin
                        cs_n_q <= 1'b1;
                        done_q <= 1'b1;
`ifdef IOCLK_EOC_WAIT_EN
                        state_q <= S_WAIT_EOC;
`else
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
`ifdef IOCLK_EOC_WAIT_EN
                S_WAIT_EOC: begin
                    cnt_q <= '0;
                    if (eoc_in && !eoc_q) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign io_clk      = io_clk_q;
    assign cs_n        = cs_n_q;
    assign sig_rising  = rise_q;
    assign sig_falling = fall_q;
    assign pulse_idx   = pidx_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
